// File: rtl/alkflag_pkg.sv
// alkflag_pkg: shared loop FSM state encodings and default loop counter width for the ALK flag stage
package alkflag_pkg;
  localparam int LOOP_W_DEF = 5;
  typedef enum logic [1:0] {
    ALK_LOOP_IDLE = 2'b00,
    ALK_LOOP_RUN  = 2'b01,
    ALK_LOOP_DONE = 2'b10
  } loop_state_t;
endpackage

// File: rtl/alkloopctr.sv
// alkloopctr: microcode loop counter FSM producing the loop busy and loop done flags
module alkloopctr
  import alkflag_pkg::*;
#(
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              ld,
  input  logic [LOOP_W-1:0] cnt_in,
  input  logic              step,
  output logic              flag,
  output logic              busy,
  output logic [LOOP_W-1:0] cnt
);
  loop_state_t state, state_nxt;
  logic [LOOP_W-1:0] cnt_nxt;
  // Load beats step; steps only count in RUN, where cnt is always nonzero.
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (ld) begin
      state_nxt = (cnt_in == '0) ? ALK_LOOP_DONE : ALK_LOOP_RUN;
      cnt_nxt = cnt_in;
    end else if (step && state == ALK_LOOP_RUN) begin
      state_nxt = (cnt == LOOP_W'(1)) ? ALK_LOOP_DONE : ALK_LOOP_RUN;
      cnt_nxt = cnt - LOOP_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= ALK_LOOP_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  assign busy = (state == ALK_LOOP_RUN);
  assign flag = (state == ALK_LOOP_DONE);
endmodule

// File: rtl/alkflag.sv
// alkflag: ALK carry / sign-corrected flag registers plus microcode loop counter
module alkflag
  import alkflag_pkg::*;
#(
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              alu_cout_h,
  input  logic              alu_n_h,
  input  logic              alu_v_h,
  input  logic              alk_cflag_ld_h,
  input  logic              alk_soflag_ld_h,
  input  logic              alk_flag_wr_h,
  input  logic [1:0]        wbus_in_h,
  input  logic              alk_flag_clr_h,
  input  logic              loop_cnt_ld_h,
  input  logic [LOOP_W-1:0] loop_cnt_in_h,
  input  logic              loop_step_h,
  output logic              alkc_flag_h,
  output logic              aluso_flag_h,
  output logic              loop_flag_h,
  output logic              loop_busy_h,
  output logic [LOOP_W-1:0] loop_cnt_h
);
  // wbus bit 1 (bus bit 31) is aluso, bit 0 (bus bit 30) is alkc
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      alkc_flag_h <= 1'b0;
      aluso_flag_h <= 1'b0;
    end else begin
      alkc_flag_h <= alk_flag_clr_h ? 1'b0 : alk_flag_wr_h ? wbus_in_h[0] :
                     alk_cflag_ld_h ? alu_cout_h : alkc_flag_h;
      aluso_flag_h <= alk_flag_clr_h ? 1'b0 : alk_flag_wr_h ? wbus_in_h[1] :
                      alk_soflag_ld_h ? (alu_n_h ^ alu_v_h) : aluso_flag_h;
    end
  end
  alkloopctr #(.LOOP_W(LOOP_W)) u_loop (
    .clk(clk),
    .reset_l(reset_l),
    .ld(loop_cnt_ld_h),
    .cnt_in(loop_cnt_in_h),
    .step(loop_step_h),
    .flag(loop_flag_h),
    .busy(loop_busy_h),
    .cnt(loop_cnt_h)
  );
endmodule

// File: tb/tb_alkflag.sv
// tb_alkflag: directed self-checking bench for the ALK flag stage and loop counter
module tb_alkflag;
  logic clk = 0, reset_l = 0;
  logic alu_cout_h = 0, alu_n_h = 0, alu_v_h = 0;
  logic alk_cflag_ld_h = 0, alk_soflag_ld_h = 0, alk_flag_wr_h = 0, alk_flag_clr_h = 0;
  logic [1:0] wbus_in_h = 0;
  logic loop_cnt_ld_h = 0, loop_step_h = 0;
  logic [4:0] loop_cnt_in_h = 0;
  logic alkc_flag_h, aluso_flag_h, loop_flag_h, loop_busy_h;
  logic [4:0] loop_cnt_h;
  int vecs = 0, errs = 0;

  alkflag #(.LOOP_W(5)) dut (
    .clk(clk), .reset_l(reset_l), .alu_cout_h(alu_cout_h), .alu_n_h(alu_n_h),
    .alu_v_h(alu_v_h), .alk_cflag_ld_h(alk_cflag_ld_h), .alk_soflag_ld_h(alk_soflag_ld_h),
    .alk_flag_wr_h(alk_flag_wr_h), .wbus_in_h(wbus_in_h), .alk_flag_clr_h(alk_flag_clr_h),
    .loop_cnt_ld_h(loop_cnt_ld_h), .loop_cnt_in_h(loop_cnt_in_h), .loop_step_h(loop_step_h),
    .alkc_flag_h(alkc_flag_h), .aluso_flag_h(aluso_flag_h), .loop_flag_h(loop_flag_h),
    .loop_busy_h(loop_busy_h), .loop_cnt_h(loop_cnt_h)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_l = 0;
    #3;
    vecs++;
    if ({alkc_flag_h, aluso_flag_h, loop_flag_h, loop_busy_h, loop_cnt_h} !== 9'b0) begin
      errs++;
      $display("FAIL reset_init got %b exp %b", {alkc_flag_h, aluso_flag_h, loop_flag_h, loop_busy_h, loop_cnt_h}, 9'b0);
    end
    tick();
    reset_l = 1;
    tick();
    alk_flag_wr_h = 1; wbus_in_h = 2'b11; loop_cnt_ld_h = 1; loop_cnt_in_h = 5'd3;
    tick();
    alk_flag_wr_h = 0; loop_cnt_ld_h = 0;
    vecs++;
    if ({loop_busy_h, loop_cnt_h, alkc_flag_h} !== {1'b1, 5'd3, 1'b1}) begin
      errs++;
      $display("FAIL reset_prep got %b exp %b", {loop_busy_h, loop_cnt_h, alkc_flag_h}, {1'b1, 5'd3, 1'b1});
    end
    #2 reset_l = 0;
    #1;
    vecs++;
    if ({alkc_flag_h, aluso_flag_h, loop_flag_h, loop_busy_h, loop_cnt_h} !== 9'b0) begin
      errs++;
      $display("FAIL reset_async got %b exp %b", {alkc_flag_h, aluso_flag_h, loop_flag_h, loop_busy_h, loop_cnt_h}, 9'b0);
    end
    tick();
    reset_l = 1;
    loop_step_h = 1;
    tick();
    tick();
    loop_step_h = 0;
    vecs++;
    if ({loop_flag_h, loop_busy_h, loop_cnt_h} !== 7'b0) begin
      errs++;
      $display("FAIL reset_steps got %b exp %b", {loop_flag_h, loop_busy_h, loop_cnt_h}, 7'b0);
    end
  endtask

  task automatic test_flags();
    alu_cout_h = 1; alu_n_h = 1; alu_v_h = 1; alk_cflag_ld_h = 1; alk_soflag_ld_h = 1;
    tick();
    vecs++;
    if ({alkc_flag_h, aluso_flag_h} !== 2'b10) begin
      errs++;
      $display("FAIL flag_load got %b exp %b", {alkc_flag_h, aluso_flag_h}, 2'b10);
    end
    alk_flag_wr_h = 1; wbus_in_h = 2'b10;
    tick();
    vecs++;
    if ({alkc_flag_h, aluso_flag_h} !== 2'b01) begin
      errs++;
      $display("FAIL flag_write got %b exp %b", {alkc_flag_h, aluso_flag_h}, 2'b01);
    end
    alk_flag_clr_h = 1;
    tick();
    vecs++;
    if ({alkc_flag_h, aluso_flag_h} !== 2'b00) begin
      errs++;
      $display("FAIL flag_clear got %b exp %b", {alkc_flag_h, aluso_flag_h}, 2'b00);
    end
    alk_flag_clr_h = 0; alk_flag_wr_h = 0; alk_cflag_ld_h = 0;
    alu_n_h = 1; alu_v_h = 0;
    tick();
    vecs++;
    if ({alkc_flag_h, aluso_flag_h} !== 2'b01) begin
      errs++;
      $display("FAIL flag_so_only got %b exp %b", {alkc_flag_h, aluso_flag_h}, 2'b01);
    end
    alk_soflag_ld_h = 0; alu_cout_h = 0; alu_n_h = 0;
    tick();
    vecs++;
    if ({alkc_flag_h, aluso_flag_h} !== 2'b01) begin
      errs++;
      $display("FAIL flag_hold got %b exp %b", {alkc_flag_h, aluso_flag_h}, 2'b01);
    end
    alk_flag_wr_h = 1; wbus_in_h = 2'b01;
    tick();
    alk_flag_wr_h = 0;
    vecs++;
    if ({alkc_flag_h, aluso_flag_h} !== 2'b10) begin
      errs++;
      $display("FAIL flag_write01 got %b exp %b", {alkc_flag_h, aluso_flag_h}, 2'b10);
    end
    alk_flag_clr_h = 1;
    tick();
    alk_flag_clr_h = 0;
  endtask

  task automatic test_loop3();
    logic [4:0] exp_cnt [4] = '{5'd3, 5'd2, 5'd1, 5'd0};
    loop_cnt_ld_h = 1; loop_cnt_in_h = 5'd3;
    tick();
    loop_cnt_ld_h = 0; loop_step_h = 1;
    for (int i = 0; i < 6; i++) begin
      logic [4:0] ec;
      logic eb;
      ec = exp_cnt[i < 3 ? i : 3];
      eb = (i < 3);
      vecs++;
      if ({loop_cnt_h, loop_busy_h, loop_flag_h} !== {ec, eb, ~eb}) begin
        errs++;
        $display("FAIL loop3_%0d got %b exp %b", i, {loop_cnt_h, loop_busy_h, loop_flag_h}, {ec, eb, ~eb});
      end
      tick();
    end
    loop_step_h = 0;
  endtask

  task automatic test_zero_load();
    reset_l = 0;
    tick();
    reset_l = 1;
    loop_cnt_ld_h = 1; loop_cnt_in_h = 5'd0;
    tick();
    loop_cnt_ld_h = 0;
    vecs++;
    if ({loop_flag_h, loop_busy_h, loop_cnt_h} !== {1'b1, 1'b0, 5'd0}) begin
      errs++;
      $display("FAIL zero_load got %b exp %b", {loop_flag_h, loop_busy_h, loop_cnt_h}, {1'b1, 1'b0, 5'd0});
    end
  endtask

  task automatic test_collision();
    loop_cnt_ld_h = 1; loop_cnt_in_h = 5'd2;
    tick();
    loop_cnt_in_h = 5'd7; loop_step_h = 1;
    tick();
    loop_cnt_ld_h = 0; loop_step_h = 0;
    vecs++;
    if ({loop_busy_h, loop_flag_h, loop_cnt_h} !== {1'b1, 1'b0, 5'd7}) begin
      errs++;
      $display("FAIL collide got %b exp %b", {loop_busy_h, loop_flag_h, loop_cnt_h}, {1'b1, 1'b0, 5'd7});
    end
    loop_cnt_ld_h = 1; loop_cnt_in_h = 5'd0;
    tick();
    loop_cnt_ld_h = 0;
    vecs++;
    if ({loop_busy_h, loop_flag_h, loop_cnt_h} !== {1'b0, 1'b1, 5'd0}) begin
      errs++;
      $display("FAIL reload_zero got %b exp %b", {loop_busy_h, loop_flag_h, loop_cnt_h}, {1'b0, 1'b1, 5'd0});
    end
  endtask

  task automatic test_max_count();
    int early = 0;
    loop_cnt_ld_h = 1; loop_cnt_in_h = 5'd31;
    tick();
    loop_cnt_ld_h = 0; loop_step_h = 1;
    vecs++;
    if ({loop_busy_h, loop_cnt_h} !== {1'b1, 5'd31}) begin
      errs++;
      $display("FAIL max_load got %b exp %b", {loop_busy_h, loop_cnt_h}, {1'b1, 5'd31});
    end
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (loop_flag_h !== 1'b0 || loop_busy_h !== 1'b1 || loop_cnt_h !== 5'(31 - i)) early++;
    end
    vecs++;
    if (early != 0) begin
      errs++;
      $display("FAIL max_run got %0d bad cycles exp 0", early);
    end
    tick();
    loop_step_h = 0;
    vecs++;
    if ({loop_flag_h, loop_busy_h, loop_cnt_h} !== {1'b1, 1'b0, 5'd0}) begin
      errs++;
      $display("FAIL max_done got %b exp %b", {loop_flag_h, loop_busy_h, loop_cnt_h}, {1'b1, 1'b0, 5'd0});
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_loop3();
    test_zero_load();
    test_collision();
    test_max_count();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
